param_reg_file: RTL and testbench
=================================

PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
- REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
- REQ-002 SHALL have parameter NUM_REGS, default 16: register count; ADDR_W = clog2(NUM_REGS).
- REQ-003 SHALL have parameter NUM_EXT, default 2: number of external-update channels.
- REQ-004 SHALL have parameter EXT_BASE, default 10: index of the first external register; channel k maps to register EXT_BASE+k.
- REQ-005 SHALL have parameter STALE_LIMIT, default 1023: cycles without an accepted update before a channel is flagged stale.
- REQ-006 SHALL have a single clock and an asynchronous, active-high reset. Ports follow.
- REQ-007 clk, input, 1: clock.
- REQ-008 reset, input, 1: asynchronous reset, active high.
- REQ-009 wr_en, input, 1: ALU write strobe.
- REQ-010 wr_addr, input, ADDR_W: ALU write address.
- REQ-011 wr_data, input, DATA_W: ALU write data.
- REQ-012 ext_data, input, NUM_EXT*DATA_W: external channel data, packed with channel 0 in the LSBs.
- REQ-013 ext_valid, input, NUM_EXT: per-channel new-sample strobe.
- REQ-014 ext_lock, input, 1: freezes external updates.
- REQ-015 rd_addr_a and rd_addr_b, input, ADDR_W each: read addresses.
- REQ-016 rd_data_a and rd_data_b, output, DATA_W each: read data.
- REQ-017 regs_flat, output, NUM_REGS*DATA_W: all registers, packed with register 0 in the LSBs.
- REQ-018 ext_pending, output, NUM_EXT: a sample is buffered while locked.
- REQ-019 ext_overrun, output, NUM_EXT: sticky flag; a pending sample was overwritten.
- REQ-020 ext_stale, output, NUM_EXT: the channel has exceeded STALE_LIMIT.

Function
- REQ-021 All state SHALL update on the falling edge of clk.
- REQ-022 Reads SHALL be combinational from stored state, with no write bypass; a same-edge write becomes visible after that edge.
- REQ-023 A non-external register SHALL load wr_data when wr_en=1 and wr_addr matches; otherwise it holds.
- REQ-024 An out-of-range wr_addr (>= NUM_REGS) SHALL be ignored, and out-of-range reads SHALL return 0.
- REQ-025 Unlocked (ext_lock=0), ext_valid[k]=1: register EXT_BASE+k SHALL load the channel's slice; an ALU write to that register on the same edge is dropped.
- REQ-026 Unlocked, ext_valid[k]=0: an ALU write to an external register SHALL be ignored.
- REQ-027 Locked, ALU writes to external registers SHALL be accepted, as a software override.
- REQ-028 Locked, ext_valid[k]=1: the sample SHALL be stored in a one-deep pending buffer and ext_pending[k] set.
- REQ-029 Locked with the buffer already full: the newest sample SHALL replace the buffered one and ext_overrun[k] set.
- REQ-030 On the first unlocked edge with ext_pending[k]=1, the register SHALL load, in priority order:
  - the live ext_valid sample if present, else
  - the pending sample;
  - ext_pending[k] then clears.
- REQ-031 ext_overrun[k] SHALL clear only on reset, or on an ALU write of any value to that channel's register while unlocked (a write-to-clear acknowledge; the data itself is discarded).
- REQ-032 Each channel SHALL have a saturating counter that:
  - resets to 0 on every accepted register update (REQ-025 or REQ-030);
  - otherwise increments each edge, saturating at STALE_LIMIT;
  - drives ext_stale[k]=1 exactly when it equals STALE_LIMIT.
- REQ-033 Pending-buffer captures SHALL NOT reset the stale counter.
- REQ-034 Channel behaviour SHALL be independent per channel, and all channels SHALL share ext_lock.

Reset
- REQ-035 While reset=1, the following SHALL be 0 asynchronously: all registers, pending buffers, ext_pending, ext_overrun, stale counters and ext_stale.
- REQ-036 Reset asserted while locked with a pending sample SHALL discard the sample, and no update is applied after release.
- REQ-037 The first falling edge after reset deassertion SHALL operate normally.

Structure
- REQ-038 The shared package SHALL hold DATA_W, NUM_REGS, NUM_EXT and EXT_BASE defaults, STALE_LIMIT, and the clog2 helper.
- REQ-039 Per-channel logic SHALL be one sub-module, ext_channel (pending buffer, overrun flag, stale counter), instantiated NUM_EXT times by generate.
- REQ-040 Elaboration SHALL fail if EXT_BASE+NUM_EXT > NUM_REGS.

Verification
- REQ-041 Reset pulse mid-run: rd_data_a=0 for every address, and all flags are 0.
- REQ-042 Write and overrides:
  - wr_en, wr_addr=3, wr_data=0xBEEF: rd_addr_a=3 reads 0xBEEF after the edge and 0 before it.
  - Unlocked, wr_addr=10, wr_data=0x1234: register 10 unchanged.
  - Locked, same write: register 10 = 0x1234.
- REQ-043 Locked pending and overrun:
  - Locked, ext_valid[0] with 0x0055: register 10 holds, ext_pending[0]=1.
  - A second sample 0x0066: ext_overrun[0]=1.
  - Unlock: register 10 = 0x0066 one edge later, ext_pending[0]=0.
- REQ-044 Unlock edge with a simultaneous ext_valid[1] carrying 0x0077 while 0x0011 is pending: register 11 = 0x0077.
- REQ-045 STALE_LIMIT=4 with no ext_valid:
  - ext_stale rises on the 4th edge after reset.
  - One accepted sample clears it on the following edge.
- REQ-046 Same-edge conflict, unlocked: wr_addr=11 with ext_valid[1] and 0x00AA: register 11 = 0x00AA.

Source files
------------

// File: rtl/param_reg_file_pkg.sv
// Shared defaults and helpers for the parameterised register file
// and its external-update channels.
package param_reg_file_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int NUM_REGS_DEF    = 16;
    localparam int NUM_EXT_DEF     = 2;
    localparam int EXT_BASE_DEF    = 10;
    localparam int STALE_LIMIT_DEF = 1023;

    // Never returns 0, so a one-entry file still gets a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/param_reg_file_ext_channel.sv
// One external-update channel: lock-time pending buffer, sticky overrun
// flag and saturating staleness counter.
module ext_channel
    import param_reg_file_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STALE_LIMIT = STALE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_lock_i,
    input  logic              ext_valid_i,
    input  logic [DATA_W-1:0] ext_data_i,
    input  logic              ack_i,
    output logic              upd_o,
    output logic [DATA_W-1:0] upd_data_o,
    output logic              pending_o,
    output logic              overrun_o,
    output logic              stale_o
);

    localparam int CNT_W = clog2(STALE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALE_LIMIT);

    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        pend_d     = pend_q;
        pdata_d    = pdata_q;
        ovr_d      = ovr_q;
        upd_o      = 1'b0;
        upd_data_o = ext_data_i;
        if (!ext_lock_i) begin
            pend_d = 1'b0;
            // A live sample is newer than anything buffered during lock.
            if (ext_valid_i) begin
                upd_o = 1'b1;
            end else if (pend_q) begin
                upd_o      = 1'b1;
                upd_data_o = pdata_q;
            end
            if (ack_i) begin
                ovr_d = 1'b0;
            end
        end else if (ext_valid_i) begin
            pdata_d = ext_data_i;
            pend_d  = 1'b1;
            if (pend_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_o) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 1'b0;
            pdata_q <= '0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            pdata_q <= pdata_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pending_o = pend_q;
    assign overrun_o = ovr_q;
    assign stale_o   = (cnt_q == LIMIT);

endmodule

// File: rtl/param_reg_file.sv
// Register file with two read ports, one ALU write port and a block of
// registers fed by lockable external-update channels.
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int NUM_EXT     = NUM_EXT_DEF,
    parameter int EXT_BASE    = EXT_BASE_DEF,
    parameter int STALE_LIMIT = STALE_LIMIT_DEF,
    parameter int ADDR_W      = clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_EXT*DATA_W-1:0]  ext_data,
    input  logic [NUM_EXT-1:0]         ext_valid,
    input  logic                       ext_lock,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    output logic [DATA_W-1:0]          rd_data_a,
    output logic [DATA_W-1:0]          rd_data_b,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_EXT-1:0]         ext_pending,
    output logic [NUM_EXT-1:0]         ext_overrun,
    output logic [NUM_EXT-1:0]         ext_stale
);

    generate
        if ((EXT_BASE + NUM_EXT) > NUM_REGS) begin : g_bad_cfg
            $error("param_reg_file: EXT_BASE+NUM_EXT exceeds NUM_REGS");
        end
    endgenerate

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_EXT-1:0] upd;
    logic [NUM_EXT-1:0] ack;
    logic [DATA_W-1:0] upd_data [NUM_EXT];

    genvar k;
    generate
        for (k = 0; k < NUM_EXT; k++) begin : g_ch
            assign ack[k] = wr_en && (wr_addr == ADDR_W'(EXT_BASE + k));

            ext_channel #(
                .DATA_W      (DATA_W),
                .STALE_LIMIT (STALE_LIMIT)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .ext_lock_i  (ext_lock),
                .ext_valid_i (ext_valid[k]),
                .ext_data_i  (ext_data[k*DATA_W +: DATA_W]),
                .ack_i       (ack[k]),
                .upd_o       (upd[k]),
                .upd_data_o  (upd_data[k]),
                .pending_o   (ext_pending[k]),
                .overrun_o   (ext_overrun[k]),
                .stale_o     (ext_stale[k])
            );
        end
    endgenerate

    // External registers only take ALU data while locked (software override).
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                if (i < EXT_BASE || i >= EXT_BASE + NUM_EXT || ext_lock) begin
                    regs_d[i] = wr_data;
                end
            end
        end
        for (int c = 0; c < NUM_EXT; c++) begin
            if (upd[c]) begin
                regs_d[EXT_BASE + c] = upd_data[c];
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = regs_q[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = regs_q[i];
            end
        end
    end

    genvar r;
    generate
        for (r = 0; r < NUM_REGS; r++) begin : g_flat
            assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
        end
    endgenerate

endmodule

// File: tb/tb_param_reg_file.sv
// Randomised and directed check of param_reg_file against a
// behavioural model of the register file and its channels.
module tb_param_reg_file;

    localparam int SL = 4;

    logic         clk;
    logic         reset;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [15:0]  wr_data;
    logic [31:0]  ext_data;
    logic [1:0]   ext_valid;
    logic         ext_lock;
    logic [3:0]   rd_addr_a;
    logic [3:0]   rd_addr_b;
    logic [15:0]  rd_data_a;
    logic [15:0]  rd_data_b;
    logic [255:0] regs_flat;
    logic [1:0]   ext_pending;
    logic [1:0]   ext_overrun;
    logic [1:0]   ext_stale;

    int n_vec;
    int n_err;

    logic [15:0] m_regs [16];
    bit          m_pend [2];
    logic [15:0] m_pval [2];
    bit          m_ovr  [2];
    int          m_cnt  [2];

    param_reg_file #(
        .DATA_W      (16),
        .NUM_REGS    (16),
        .NUM_EXT     (2),
        .EXT_BASE    (10),
        .STALE_LIMIT (SL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ext_data    (ext_data),
        .ext_valid   (ext_valid),
        .ext_lock    (ext_lock),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .regs_flat   (regs_flat),
        .ext_pending (ext_pending),
        .ext_overrun (ext_overrun),
        .ext_stale   (ext_stale)
    );

    initial clk = 1'b1;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0;
            m_pval[c] = '0;
            m_ovr[c]  = 0;
            m_cnt[c]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] nr [16];
        logic [15:0] d;
        int          ra;
        bit          hit;
        bit          acc;
        for (int i = 0; i < 16; i++) nr[i] = m_regs[i];
        if (wr_en && (wr_addr < 10 || wr_addr > 11)) nr[wr_addr] = wr_data;
        for (int c = 0; c < 2; c++) begin
            ra  = 10 + c;
            d   = ext_data[c*16 +: 16];
            hit = wr_en && (int'(wr_addr) == ra);
            acc = 0;
            if (!ext_lock) begin
                if (ext_valid[c]) begin
                    nr[ra] = d;
                    acc = 1;
                end else if (m_pend[c]) begin
                    nr[ra] = m_pval[c];
                    acc = 1;
                end
                m_pend[c] = 0;
                if (hit) m_ovr[c] = 0;
            end else begin
                if (hit) nr[ra] = wr_data;
                if (ext_valid[c]) begin
                    if (m_pend[c]) m_ovr[c] = 1;
                    m_pend[c] = 1;
                    m_pval[c] = d;
                end
            end
            if (acc) m_cnt[c] = 0;
            else if (m_cnt[c] < SL) m_cnt[c] = m_cnt[c] + 1;
        end
        for (int i = 0; i < 16; i++) m_regs[i] = nr[i];
    endtask

    task automatic compare_all();
        logic [255:0] ef;
        logic [1:0]   ep, eo, es;
        for (int i = 0; i < 16; i++) ef[i*16 +: 16] = m_regs[i];
        for (int c = 0; c < 2; c++) begin
            ep[c] = m_pend[c];
            eo[c] = m_ovr[c];
            es[c] = (m_cnt[c] == SL);
        end
        chk("rd_a", rd_data_a, m_regs[rd_addr_a]);
        chk("rd_b", rd_data_b, m_regs[rd_addr_b]);
        chk("flat", regs_flat, ef);
        chk("pending", ext_pending, ep);
        chk("overrun", ext_overrun, eo);
        chk("stale", ext_stale, es);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        ext_valid = '0;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            #1;
            chk("rst_rd", rd_data_a, 16'h0);
        end
        chk("rst_flags", {ext_pending, ext_overrun, ext_stale}, 6'h0);
        model_reset();
        #3 reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        ext_data = '0;
        ext_valid = '0;
        ext_lock = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        model_reset();
        #25;
        compare_all();
        #5 reset = 1'b0;

        step(); step(); step();
        chk("stale_e3", ext_stale, 2'b00);
        step();
        chk("stale_e4", ext_stale, 2'b11);
        ext_data = {16'h0002, 16'h0001};
        ext_valid = 2'b11;
        step();
        chk("stale_clr", ext_stale, 2'b00);
        idle();

        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr_a = 4'd3;
        #1 chk("wr_before", rd_data_a, 16'h0);
        step();
        chk("wr_after", rd_data_a, 16'hBEEF);

        wr_addr = 4'd10; wr_data = 16'h1234; rd_addr_a = 4'd10;
        step();
        chk("ext_wr_unlk", rd_data_a, 16'h0001);
        ext_lock = 1'b1;
        step();
        chk("ext_wr_lk", rd_data_a, 16'h1234);
        idle();

        ext_data = {16'h0000, 16'h0055}; ext_valid = 2'b01;
        step();
        chk("pend_hold", rd_data_a, 16'h1234);
        chk("pend_set", ext_pending[0], 1'b1);
        ext_data = {16'h0000, 16'h0066};
        step();
        chk("ovr_set", ext_overrun[0], 1'b1);
        idle();
        ext_lock = 1'b0;
        step();
        chk("unlk_load", rd_data_a, 16'h0066);
        chk("unlk_pclr", ext_pending[0], 1'b0);

        ext_lock = 1'b1; rd_addr_b = 4'd11;
        ext_data = {16'h0011, 16'h0000}; ext_valid = 2'b10;
        step();
        ext_lock = 1'b0;
        ext_data = {16'h0077, 16'h0000};
        step();
        chk("unlk_live", rd_data_b, 16'h0077);

        wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'hFFFF;
        ext_data = {16'h00AA, 16'h0000}; ext_valid = 2'b10;
        step();
        chk("conflict", rd_data_b, 16'h00AA);
        idle();

        wr_en = 1'b1; wr_addr = 4'd10; wr_data = 16'h5A5A;
        step();
        chk("ovr_ack", ext_overrun[0], 1'b0);
        idle();

        ext_lock = 1'b1; ext_data = {16'h0000, 16'h0042}; ext_valid = 2'b01;
        step();
        idle();
        reset_pulse();
        ext_lock = 1'b0; rd_addr_a = 4'd10;
        step();
        chk("rst_discard", rd_data_a, 16'h0);

        for (int n = 0; n < 600; n++) begin
            wr_en     = 1'($urandom);
            wr_addr   = ($urandom_range(0, 2) == 0) ? 4'(10 + $urandom_range(0, 1))
                                                   : 4'($urandom);
            wr_data   = 16'($urandom);
            ext_data  = $urandom;
            ext_valid = ($urandom_range(0, 3) == 0) ? 2'(3 & $urandom) : 2'b00;
            if ($urandom_range(0, 5) == 0) ext_lock = ~ext_lock;
            rd_addr_a = 4'($urandom);
            rd_addr_b = 4'($urandom);
            step();
            if ($urandom_range(0, 150) == 0) reset_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
